// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor (package sub_pkg).
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEF = 4;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output sub_state_t       o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SUB_OVERFLOW_EN
  logic             r_bmsb;
`endif

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_shift;

  full_subtractor u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  // New bit enters at the MSB; after the last bit this is the full difference.
  assign w_shift = {w_d, r_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      r_bmsb  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res  <= w_shift[WIDTH-1:1];
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_br   <= w_bo;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_diff  <= w_shift;
            r_bout  <= w_bo;
`ifdef SUB_OVERFLOW_EN
            // Borrow entering the sign bit; XOR with borrow-out gives signed overflow.
            r_bmsb  <= r_br;
`endif
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign diff        = r_diff;
  assign bout        = r_bout;
  assign o_dbg_state = r_state;
`ifdef SUB_OVERFLOW_EN
  assign ovf         = r_bmsb ^ r_bout;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): directed cases, backpressure,
// reset during RUN and randomized traffic against an arithmetic reference model.
module tb_serial_subtractor;
  import sub_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf_w;
  sub_state_t   dbg_state;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff        (diff),
    .bout        (bout),
`ifdef SUB_OVERFLOW_EN
    .ovf         (ovf_w),
`endif
    .o_dbg_state (dbg_state)
  );

`ifndef SUB_OVERFLOW_EN
  assign ovf_w = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int n_issued = 0;
  int n_out = 0;
  int acc_cyc = 0;
  logic hold_ready = 1'b0;
  logic rand_bp = 1'b0;
  logic prev_ov = 1'b0;

  // expected packed as {ovf, bout, diff}
  logic [W+1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input int ai, input int bi, input int ci);
    int d, sa, sb, sd;
    logic [W-1:0] dv;
    logic bo, ov;
    d  = ai - bi - ci;
    dv = W'(d & ((1 << W) - 1));
    bo = (d < 0);
    sa = (ai >= (1 << (W-1))) ? ai - (1 << W) : ai;
    sb = (bi >= (1 << (W-1))) ? bi - (1 << W) : bi;
    sd = sa - sb - ci;
    ov = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
    return {ov, bo, dv};
  endfunction

  // consumer: out_ready changes just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready) out_ready = 1'b0;
      else if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1'b1;
    end
  end

  // monitor: latency on rising out_valid, result compare on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) chk("latency", cyc - acc_cyc, W);
      if (out_valid && out_ready) begin
        logic [W+1:0] e;
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("diff", diff, e[W-1:0]);
          chk("bout", bout, e[W]);
`ifdef SUB_OVERFLOW_EN
          chk("ovf", ovf_w, e[W+1]);
`endif
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      $display("FAIL wait_ready: in_ready stuck low");
      bad++;
      total++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
    end
  endtask

  task automatic do_op(input int ai, input int bi, input int ci, input bit pulse);
    wait_ready();
    a = W'(ai);
    b = W'(bi);
    bin = ci[0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    exp_q.push_back(model(ai, bi, ci));
    n_issued++;
    in_valid = 1'b0;
    if (pulse) begin
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int da[5] = '{5, 3, 0, 8, 7};
    int db[5] = '{3, 5, 0, 1, 15};
    int dc[5] = '{0, 0, 1, 0, 0};
    logic [W-1:0] held;

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf_w, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) do_op(da[i], db[i], dc[i], 1'b0);

    // backpressure: result must hold while out_ready is low
    wait_ready();
    hold_ready = 1'b1;
    do_op(9, 2, 0, 1'b1);
    repeat (W - 1) @(posedge clk);
    @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_diff", diff, 7);
    held = diff;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_diff", diff, held);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    hold_ready = 1'b0;

    // reset in the middle of RUN discards the operation
    do_op(12, 3, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bout, 0);
    chk("mid_rst_ovf", ovf_w, 0);
    exp_q.delete();
    n_issued--;
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(9, 4, 0, 1'b0);

    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++)
      do_op($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
            $urandom_range(0, 1), ($urandom_range(0, 2) == 0));

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    chk("output_count", n_out, n_issued);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, multi-cycle subtractor computing `diff = a - b - bin`. It processes one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It sits beside the combinational adder in the processor datapath as the area-cheap inverse operation. Operands enter and results leave through valid/ready handshakes.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits; must be ≥ 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand set present.
- `in_ready` output 1: block can accept an operand set.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `bin` input 1: borrow-in.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: difference, `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: borrow-out; 1 iff `a < b + bin` as unsigned values.
- `ovf` output 1: signed overflow; present only with `SUB_OVERFLOW_EN`.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, the block captures `a` and `b` into shift registers, loads the borrow register with `bin`, clears the bit counter and moves to RUN.
- **RUN**
  - Each cycle the cell computes `d = a_sr[0] ^ b_sr[0] ^ br` and `br' = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br)`.
  - `d` shifts into the MSB of the result register, which shifts right.
  - `a_sr` and `b_sr` shift right.
  - The counter increments; after bit WIDTH-1 is processed the block moves to DONE.
- **DONE**
  - `out_valid` = 1; `diff` and `bout` are stable.
  - On `out_valid && out_ready`, the block returns to IDLE.
- `in_ready` is 0 in RUN and DONE. `in_valid` asserted there is ignored and the operands are not latched.
- `diff`, `bout` and `ovf` hold their last values until the next result overwrites them. Consumers must sample them only while `out_valid` is 1.
- The counter is `$clog2(WIDTH)+1` bits wide and never wraps inside one operation.

## Timing
- Reset, asynchronous on `rst_n` low:
  - state goes to IDLE;
  - `in_ready` = 1 immediately;
  - `out_valid`, `diff`, `bout`, `ovf`, the borrow register and the counter go to 0.
- A reset in RUN or DONE discards the operation in progress; no partial result becomes valid.
- Latency: `out_valid` rises exactly WIDTH rising edges after the accepting edge.
- Throughput: the earliest next accept is the edge after the output handshake edge, giving a minimum period of WIDTH+2 cycles.
- `in_ready` and `out_valid` are combinational decodes of state only. There is no input-to-output combinational path.
- Backpressure: `out_ready` low in DONE holds the state and all outputs indefinitely.
- Asserting `in_valid` in the same cycle as the DONE handshake is not accepted. It is accepted one cycle later, in IDLE.

## Configuration
- `SUB_OVERFLOW_EN` defined:
  - A registered borrow-into-MSB bit is captured while processing bit WIDTH-1.
  - `ovf` = that bit XOR `bout`, valid in DONE.
  - This equals two's-complement overflow of `a - b - bin`.
- Undefined: the `ovf` port, its register and its logic are absent.

## Structure
- Package `sub_pkg` holds:
  - the state enum `sub_state_t` {IDLE, RUN, DONE};
  - the default width constant `SUB_WIDTH_DEF` = 4.
- Sub-module `full_subtractor` has inputs `a`, `b`, `bin` and outputs `d`, `bout`. It is purely combinational and is instantiated once for the bit-serial cell.
- The top module holds the FSM, shift registers, borrow flop and counter.

## Test plan
All scenarios use WIDTH=4.
- Basic subtraction: a=5, b=3, bin=0 → `diff`=2, `bout`=0, `ovf`=0, with `out_valid` 4 edges after accept.
- Unsigned wrap: a=3, b=5, bin=0 → `diff`=0xE, `bout`=1, `ovf`=0.
- Borrow-in only: a=0, b=0, bin=1 → `diff`=0xF, `bout`=1.
- Signed overflow with `SUB_OVERFLOW_EN`: a=8, b=1 → `diff`=7, `bout`=0, `ovf`=1. Also a=7, b=0xF → `diff`=8, `bout`=1, `ovf`=1.
- Backpressure and busy-ignore:
  - hold `out_ready` low 5 cycles in DONE → `diff`/`out_valid` stable, no second result;
  - `in_valid` pulsed during RUN → ignored, `in_ready`=0.
- Reset mid-RUN: drop `rst_n` after 2 processing edges → `in_ready`=1, `out_valid`=0 immediately, all outputs 0. The next operation, 9−4, yields `diff`=5.
